// File: rtl/tank_pkg.sv
// Shared types and keycode map for the tank input command stage.
// Direction encoding matches what the mover stages expect on pX_dir.
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    MV_IDLE   = 2'd0,
    MV_DELAY  = 2'd1,
    MV_REPEAT = 2'd2
  } mv_state_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
    logic fire;
  } player_cmd_t;

  localparam int unsigned NUM_SLOTS = 4;

  localparam logic [7:0] KEY_NONE = 8'h00;

  localparam logic [7:0] KEY_P1_UP    = 8'h1A;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h07;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h16;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h04;
  localparam logic [7:0] KEY_P1_FIRE  = 8'h2C;

  localparam logic [7:0] KEY_P2_UP    = 8'h52;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h51;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h50;
  localparam logic [7:0] KEY_P2_FIRE  = 8'h28;

  // Decode one slot for one player; unmapped codes yield all-zero.
  function automatic player_cmd_t decode_key(
    input logic [7:0] k,
    input logic       p2
  );
    player_cmd_t c;
    c = '0;
    if (!p2) begin
      case (k)
        KEY_P1_UP:    begin c.valid = 1'b1; c.dir = UP;    end
        KEY_P1_RIGHT: begin c.valid = 1'b1; c.dir = RIGHT; end
        KEY_P1_DOWN:  begin c.valid = 1'b1; c.dir = DOWN;  end
        KEY_P1_LEFT:  begin c.valid = 1'b1; c.dir = LEFT;  end
        KEY_P1_FIRE:  c.fire = 1'b1;
        default:      c = '0;
      endcase
    end else begin
      case (k)
        KEY_P2_UP:    begin c.valid = 1'b1; c.dir = UP;    end
        KEY_P2_RIGHT: begin c.valid = 1'b1; c.dir = RIGHT; end
        KEY_P2_DOWN:  begin c.valid = 1'b1; c.dir = DOWN;  end
        KEY_P2_LEFT:  begin c.valid = 1'b1; c.dir = LEFT;  end
        KEY_P2_FIRE:  c.fire = 1'b1;
        default:      c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// One player's move auto-repeat FSM plus fire edge detect and cooldown.
// All outputs are registered; strobes last exactly one frame.
module key_repeat_fsm
  import tank_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_RATE   = 8,
  parameter int unsigned FIRE_COOLDOWN = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dir_valid_i,
  input  dir_t dir_i,
  input  logic fire_i,
  output logic move_o,
  output dir_t dir_o,
  output logic fire_o
);

  localparam int unsigned CNT_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned CD_W =
    (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;

  localparam logic [CNT_W-1:0] DLY_LD =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LD =
    CNT_W'(REPEAT_RATE - 1);
  localparam logic [CD_W-1:0] CD_LD =
    CD_W'(FIRE_COOLDOWN - 1);

  mv_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;
  logic             move_q, move_d;
  logic             fire_q, fire_d;
  logic [CD_W-1:0]  cool_q, cool_d;
  logic             fprev_q, fprev_d;

  // State, counters and registered strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MV_IDLE;
      cnt_q   <= '0;
      dir_q   <= UP;
      move_q  <= 1'b0;
      fire_q  <= 1'b0;
      cool_q  <= '0;
      fprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      fire_q  <= fire_d;
      cool_q  <= cool_d;
      fprev_q <= fprev_d;
    end
  end

  // Next-state: move repeat timing and fire cooldown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    move_d  = 1'b0;
    fire_d  = 1'b0;
    cool_d  = cool_q;
    fprev_d = fire_i;

    unique case (state_q)
      MV_IDLE: begin
        if (dir_valid_i) begin
          move_d  = 1'b1;
          dir_d   = dir_i;
          cnt_d   = DLY_LD;
          state_d = MV_DELAY;
        end
      end
      MV_DELAY, MV_REPEAT: begin
        if (!dir_valid_i) begin
          state_d = MV_IDLE;
        end else if (dir_i != dir_q) begin
          move_d  = 1'b1;
          dir_d   = dir_i;
          cnt_d   = DLY_LD;
          state_d = MV_DELAY;
        end else if (cnt_q == '0) begin
          move_d  = 1'b1;
          cnt_d   = RATE_LD;
          state_d = MV_REPEAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MV_IDLE;
    endcase

    if (fire_i && !fprev_q && cool_q == '0) begin
      fire_d = 1'b1;
      cool_d = CD_LD;
    end else if (cool_q != '0) begin
      cool_d = cool_q - 1'b1;
    end
  end

  assign move_o = move_q;
  assign dir_o  = dir_q;
  assign fire_o = fire_q;

endmodule

// File: rtl/tank_input_ctrl.sv
// Decodes four HID keycode slots into per-player move/fire strobes.
// Lowest-numbered slot with a direction key wins per player.
module tank_input_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_RATE   = 8,
  parameter int unsigned FIRE_COOLDOWN = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  output logic       p1_move,
  output logic [1:0] p1_dir,
  output logic       p1_fire,
  output logic       p2_move,
  output logic [1:0] p2_dir,
  output logic       p2_fire
);

  logic [7:0]  slot_w [NUM_SLOTS];
  player_cmd_t p1_cmd, p2_cmd;
  player_cmd_t p1_k, p2_k;
  dir_t        p1_dir_w, p2_dir_w;

  assign slot_w[0] = keycode0;
  assign slot_w[1] = keycode1;
  assign slot_w[2] = keycode2;
  assign slot_w[3] = keycode3;

  // Scan high to low so the lowest slot's direction lands last.
  always_comb begin
    p1_cmd = '0;
    p2_cmd = '0;
    p1_k   = '0;
    p2_k   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      p1_k = decode_key(slot_w[i], 1'b0);
      p2_k = decode_key(slot_w[i], 1'b1);
      if (p1_k.valid) begin
        p1_cmd.valid = 1'b1;
        p1_cmd.dir   = p1_k.dir;
      end
      if (p2_k.valid) begin
        p2_cmd.valid = 1'b1;
        p2_cmd.dir   = p2_k.dir;
      end
      if (p1_k.fire) p1_cmd.fire = 1'b1;
      if (p2_k.fire) p2_cmd.fire = 1'b1;
    end
  end

  key_repeat_fsm #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .FIRE_COOLDOWN(FIRE_COOLDOWN)
  ) u_p1 (
    .clk_i      (frame_clk),
    .rst_i      (Reset),
    .dir_valid_i(p1_cmd.valid),
    .dir_i      (p1_cmd.dir),
    .fire_i     (p1_cmd.fire),
    .move_o     (p1_move),
    .dir_o      (p1_dir_w),
    .fire_o     (p1_fire)
  );

  key_repeat_fsm #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .FIRE_COOLDOWN(FIRE_COOLDOWN)
  ) u_p2 (
    .clk_i      (frame_clk),
    .rst_i      (Reset),
    .dir_valid_i(p2_cmd.valid),
    .dir_i      (p2_cmd.dir),
    .fire_i     (p2_cmd.fire),
    .move_o     (p2_move),
    .dir_o      (p2_dir_w),
    .fire_o     (p2_fire)
  );

  assign p1_dir = p1_dir_w;
  assign p2_dir = p2_dir_w;

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Directed bench for tank_input_ctrl: vector table plus
// hand-written repeat, fire-cooldown and reset sequences.
module tb_tank_input_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] k0, k1, k2, k3;
  logic       p1_move, p1_fire, p2_move, p2_fire;
  logic [1:0] p1_dir, p2_dir;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] k0, k1, k2, k3;
    logic       m1;
    logic [1:0] d1;
    logic       f1;
    logic       m2;
    logic [1:0] d2;
    logic       f2;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  tank_input_ctrl dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .keycode0 (k0),
    .keycode1 (k1),
    .keycode2 (k2),
    .keycode3 (k3),
    .p1_move  (p1_move),
    .p1_dir   (p1_dir),
    .p1_fire  (p1_fire),
    .p2_move  (p2_move),
    .p2_dir   (p2_dir),
    .p2_fire  (p2_fire)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic setk(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    k0 = a; k1 = b; k2 = c; k3 = d;
  endtask

  task automatic chk_all(input string tag,
                         input logic m1, input logic [1:0] d1,
                         input logic f1, input logic m2,
                         input logic [1:0] d2, input logic f2);
    chk({tag, " p1_move"}, 8'(p1_move), 8'(m1));
    chk({tag, " p1_dir"},  8'(p1_dir),  8'(d1));
    chk({tag, " p1_fire"}, 8'(p1_fire), 8'(f1));
    chk({tag, " p2_move"}, 8'(p2_move), 8'(m2));
    chk({tag, " p2_dir"},  8'(p2_dir),  8'(d2));
    chk({tag, " p2_fire"}, 8'(p2_fire), 8'(f2));
  endtask

  function automatic vec_t mk(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] d,
    input logic m1, input logic [1:0] d1, input logic f1,
    input logic m2, input logic [1:0] d2, input logic f2);
    vec_t v;
    v.k0 = a; v.k1 = b; v.k2 = c; v.k3 = d;
    v.m1 = m1; v.d1 = d1; v.f1 = f1;
    v.m2 = m2; v.d2 = d2; v.f2 = f2;
    return v;
  endfunction

  initial begin
    logic ex;
    logic held;
    logic [1:0] ed;

    vecs[0]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0, 0, 0);
    vecs[1]  = mk(8'h04, 8'h50, 8'h00, 8'h00, 1, 3, 0, 1, 3, 0);
    vecs[2]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 0, 0, 3, 0);
    vecs[3]  = mk(8'h16, 8'h1A, 8'h00, 8'h00, 1, 2, 0, 0, 3, 0);
    vecs[4]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0, 3, 0);
    vecs[5]  = mk(8'h05, 8'h05, 8'h00, 8'h05, 0, 2, 0, 0, 3, 0);
    vecs[6]  = mk(8'h2C, 8'h28, 8'h00, 8'h00, 0, 2, 1, 0, 3, 1);
    vecs[7]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0, 3, 0);
    vecs[8]  = mk(8'h1A, 8'h1A, 8'h4F, 8'h00, 1, 0, 0, 1, 1, 0);
    vecs[9]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk(8'h50, 8'h07, 8'h00, 8'h51, 1, 1, 0, 1, 3, 0);
    vecs[11] = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 3, 0);
    vecs[12] = mk(8'h00, 8'h00, 8'h2C, 8'h00, 0, 1, 0, 0, 3, 0);
    vecs[13] = mk(8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 3, 0);

    setk(8'h00, 8'h00, 8'h00, 8'h00);
    #1 Reset = 1'b1;
    #7;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    #4 Reset = 1'b0;
    tick();
    chk_all("post-reset idle", 0, 0, 0, 0, 0, 0);

    setk(8'h1A, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 40; i++) begin
      tick();
      ex = (i == 0) || (i >= 16 && (i - 16) % 8 == 0);
      chk_all($sformatf("hold-W f%0d", i), ex, 0, 0, 0, 0, 0);
    end
    setk(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_all("release-W", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      setk((i < 5) ? 8'h07 : 8'h16, 8'h00, 8'h00, 8'h00);
      tick();
      ex = (i == 0) || (i == 5) || (i == 21);
      ed = (i < 5) ? 2'd1 : 2'd2;
      chk({"dchg p1_move ", $sformatf("f%0d", i)},
          8'(p1_move), 8'(ex));
      chk({"dchg p1_dir ", $sformatf("f%0d", i)},
          8'(p1_dir), 8'(ed));
    end
    setk(8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    for (int v = 0; v < NV; v++) begin
      setk(vecs[v].k0, vecs[v].k1, vecs[v].k2, vecs[v].k3);
      tick();
      chk_all($sformatf("vec%0d", v),
              vecs[v].m1, vecs[v].d1, vecs[v].f1,
              vecs[v].m2, vecs[v].d2, vecs[v].f2);
    end

    for (int i = 0; i < 35; i++) tick();

    setk(8'h00, 8'h00, 8'h2C, 8'h00);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("fire-held f%0d", i),
          8'(p1_fire), 8'(i == 0));
    end
    setk(8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 35; i++) tick();

    for (int i = 0; i < 33; i++) begin
      held = (i < 10) || (i >= 20 && i < 25) || (i >= 31);
      setk(8'h00, 8'h00, held ? 8'h2C : 8'h00, 8'h00);
      tick();
      chk($sformatf("fire-cd f%0d", i),
          8'(p1_fire), 8'((i == 0) || (i == 31)));
      chk($sformatf("fire-cd p1_move f%0d", i),
          8'(p1_move), 8'h00);
    end
    setk(8'h00, 8'h00, 8'h00, 8'h00);
    tick();

    setk(8'h4F, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 17; i++) begin
      tick();
      ex = (i == 0) || (i == 16);
      chk($sformatf("p2-right f%0d", i), 8'(p2_move), 8'(ex));
      chk($sformatf("p2-right dir f%0d", i), 8'(p2_dir), 8'd1);
    end
    #2 Reset = 1'b1;
    setk(8'h52, 8'h00, 8'h00, 8'h00);
    #1;
    chk("async rst p2_move", 8'(p2_move), 8'h00);
    chk("async rst p2_dir", 8'(p2_dir), 8'h00);
    tick();
    chk_all("held in reset", 0, 0, 0, 0, 0, 0);
    #3 Reset = 1'b0;
    tick();
    chk_all("first edge after reset", 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("second edge after reset", 0, 0, 0, 0, 0, 0);
    setk(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk_all("final idle", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tank_input_ctrl.md
# tank_input_ctrl

Upstream command stage for the two tank movers. Each frame it decodes up to four concurrent USB HID keycodes into per-player move commands (direction plus a one-frame move strobe) and fire strobes. It applies press/auto-repeat timing so a held key produces a controlled step rate rather than one tile step per frame. The tank movement stages and the projectile logic consume its outputs.

## Interface
Parameters:
- REPEAT_DELAY, 16: frames from initial move strobe to first auto-repeat strobe.
- REPEAT_RATE, 8: frames between subsequent auto-repeat strobes.
- FIRE_COOLDOWN, 30: frames after a fire strobe during which that player's fire key is ignored.

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset  in  1  asynchronous, active-high.
- keycode0..keycode3  in  8 each  HID keycodes currently held; 8'h00 = empty slot.
- p1_move  out  1  one-cycle strobe: player 1 takes one step.
- p1_dir  out  2  player 1 direction: 0 up, 1 right, 2 down, 3 left.
- p1_fire  out  1  one-cycle strobe: player 1 fires.
- p2_move, p2_dir, p2_fire  out  1/2/1  same meaning for player 2.

## Operation
- Key map, player 1: 8'h1A W up, 8'h07 D right, 8'h16 S down, 8'h04 A left, 8'h2C space fire.
- Key map, player 2: 8'h52 up, 8'h4F right, 8'h51 down, 8'h50 left, 8'h28 Enter fire.
- Direction select per player: the lowest-numbered slot holding one of that player's direction keys wins. Other slots are ignored, and the two players' decoding is independent.
- Per-player movement FSM, with states IDLE, DELAY and REPEAT and a counter sized for max(REPEAT_DELAY, REPEAT_RATE):
  - IDLE: when a direction key is held, pulse move, latch dir, load counter = REPEAT_DELAY-1, go to DELAY.
  - DELAY / REPEAT, key released: go to IDLE with no pulse. dir holds its last value.
  - DELAY / REPEAT, selected dir differs from the latched dir: pulse move immediately with the new dir, load REPEAT_DELAY-1, go to DELAY.
  - DELAY / REPEAT, counter == 0 with the same dir held: pulse move, load REPEAT_RATE-1, go to REPEAT.
  - Otherwise: decrement the counter.
- Fire, per player: strobe on the rising edge of "fire key present in any slot", but only when cooldown == 0. The strobe loads cooldown = FIRE_COOLDOWN-1. Cooldown decrements to 0 and saturates there. A key still held when cooldown expires does not fire; a new press is required.
- Move and fire are independent, so both strobes may assert in the same cycle.
- A keycode belonging to neither map is ignored. Duplicate keycodes across slots are treated as a single key.

## Timing
- All outputs are registered. A keycode present at rising edge k produces a strobe high from edge k until edge k+1, giving 1-frame latency.
- Held key: strobes at k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, and so on.
- Reset values: every strobe 0, p1_dir = p2_dir = 0, FSMs in IDLE, counters 0, cooldowns 0, fire-edge history 0.
- Reset asserted mid-repeat: next state after release is IDLE. A key still held when Reset deasserts counts as a new press and strobes on the first edge after deassertion.
- Strobes never exceed one cycle unless a new event fires on the next edge.

## Structure
- Shared package tank_pkg holds:
  - dir_t enum: UP = 0, RIGHT = 1, DOWN = 2, LEFT = 3.
  - Keycode localparams for both players' maps.
  - The movement state enum.
- Sub-module key_repeat_fsm holds one player's movement FSM, counter and fire/cooldown logic. It is instantiated twice, fed by a per-player combinational decoder in the top level.

## Test plan
- Reset, then keycode0 = 8'h1A held 40 frames: p1_move strobes at frames 0, 16, 24, 32; p1_dir = 0 throughout; p2 outputs stay 0.
- keycode0 = 8'h07 for 5 frames, then 8'h16: strobes at frame 0 (dir 1) and frame 5 (dir 2); next strobe at frame 21.
- keycode0 = 8'h04, keycode1 = 8'h50 simultaneously: p1_move and p2_move both strobe on the same edge, p1_dir = 3 and p2_dir = 3. keycode0 = 8'h16 with keycode1 = 8'h1A: p1_dir = 2 (slot 0 wins).
- keycode2 = 8'h2C held 50 frames: exactly one p1_fire strobe at frame 0. Release at frame 10 and re-press at frame 20: no strobe. Re-press at frame 31 or later: strobe.
- keycode0 = 8'h52 held and Reset pulsed at frame 20: outputs clear asynchronously, and p2_move strobes on the first edge after deassertion with p2_dir = 0.
- All slots 8'h00 or unmapped codes (8'h05): no strobes, dirs unchanged.
